// File: rtl/serial_alu.sv
// Digit-serial ALU: one DIGIT-bit slice per clock, LSB first, carry held between slices.
// Optional macro SERIAL_ALU_FLAGS_EN adds registered carry/overflow/zero flags.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | processing one digit per edge, N edges total
// DONE  | result held until out_ready; may accept next request on same edge
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh, b_sh, res_q;
  logic [2:0]             op;
  logic                   cy;
  logic [CW-1:0]          cnt;
  logic                   out_valid_q;
  logic                   accept, last, invert, ovf_dig;
  logic [DIGIT-1:0]       a_d, b_d, dig;
  logic [DIGIT:0]         sum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift, res_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: if (last) state_nxt = DONE;
      DONE: if (out_ready) begin
        in_ready  = 1'b1;
        state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign last   = (state == RUN) && (cnt == LAST);

  // Subtraction-style ops add ~b with the carry register preset to 1.
  assign invert  = (op == OP_SUB) || (op == OP_SLT);
  assign a_d     = a_sh[DIGIT-1:0];
  assign b_d     = invert ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
  assign sum     = {1'b0, a_d} + {1'b0, b_d} + (DIGIT+1)'(cy);
  assign ovf_dig = (a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum[DIGIT-1]) ^ sum[DIGIT];

  always_comb begin
    dig = sum[DIGIT-1:0];
    case (op)
      OP_XOR:  dig = a_d ^ b_sh[DIGIT-1:0];
      OP_AND:  dig = a_d & b_sh[DIGIT-1:0];
      OP_NAND: dig = ~(a_d & b_sh[DIGIT-1:0]);
      OP_NOR:  dig = ~(a_d | b_sh[DIGIT-1:0]);
      OP_OR:   dig = a_d | b_sh[DIGIT-1:0];
      default: dig = sum[DIGIT-1:0];
    endcase
  end

  assign res_cat   = {dig, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign res_final = (op == OP_SLT) ? WIDTH'(sum[DIGIT-1] ^ ovf_dig) : res_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      op          <= OP_ADD;
      cy          <= 1'b0;
      cnt         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      a_sh        <= a;
      b_sh        <= b;
      op          <= sel;
      cy          <= (sel == OP_SUB) || (sel == OP_SLT);
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      cy    <= sum[DIGIT];
      cnt   <= cnt + CW'(1);
      res_q <= last ? res_final : res_shift;
      if (last) out_valid_q <= 1'b1;
    end else if (state == DONE && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;

`ifdef SERIAL_ALU_FLAGS_EN
  logic carry_q, ovf_q, zero_q, is_arith;
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (last) begin
      carry_q <= is_arith & sum[DIGIT];
      ovf_q   <= is_arith & ovf_dig;
      zero_q  <= (res_final == '0);
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32, DIGIT=4): reference model plus directed literals.
module tb_serial_alu;
  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N = WIDTH / DIGIT;
`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0] sel = 3'b0;
  logic [WIDTH-1:0] a = '0, b = '0, result;
  logic carry, overflow, zero;

  int checks = 0, errors = 0;

  typedef struct { logic [WIDTH-1:0] r; logic c, o, z; } exp_t;
  exp_t q[$];

  serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    logic [WIDTH:0] t;
    e.c = 1'b0; e.o = 1'b0;
    case (s)
      3'd0: begin
        t = {1'b0, x} + {1'b0, y};
        e.r = t[WIDTH-1:0]; e.c = t[WIDTH];
        e.o = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
      end
      3'd1: begin
        t = {1'b0, x} + {1'b0, ~y} + 1;
        e.r = t[WIDTH-1:0]; e.c = t[WIDTH];
        e.o = (x[WIDTH-1] != y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
      end
      3'd2: e.r = x ^ y;
      3'd3: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      3'd4: e.r = x & y;
      3'd5: e.r = ~(x & y);
      3'd6: e.r = ~(x | y);
      default: e.r = x | y;
    endcase
    e.c = e.c & FL;
    e.o = e.o & FL;
    e.z = (e.r == 0) & FL;
    return e;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        check("mdl_result",   result,   q[0].r);
        check("mdl_carry",    carry,    q[0].c);
        check("mdl_overflow", overflow, q[0].o);
        check("mdl_zero",     zero,     q[0].z);
      end
    end
  end

  always @(posedge clk) if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());

  task automatic start(input logic [2:0] s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    check("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; sel = s; a = x; b = y;
    q.push_back(model(s, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0; sel = $urandom_range(7, 0); a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input string name);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check(name, lat, N);
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] r, input logic c, input logic o, input logic z);
    check({name, "_result"}, result, r);
    check({name, "_carry"}, carry, c & FL);
    check({name, "_overflow"}, overflow, o & FL);
    check({name, "_zero"}, zero, z & FL);
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
  endtask

  task automatic op_lit(input string name, input logic [2:0] s, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] r,
                        input logic c, input logic o, input logic z);
    start(s, x, y);
    wait_result({name, "_latency"});
    lit(name, r, c, o, z);
    release_out();
  endtask

  initial begin
    logic [WIDTH-1:0] held_r;
    logic held_c, held_o, held_z;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    lit("rst", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    op_lit("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1);
    op_lit("sub_ovf",  3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0);
    op_lit("sub_eq",   3'd1, 32'd5, 32'd5, 32'h0, 1, 0, 1);
    op_lit("slt_neg",  3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h1, 0, 0, 0);
    op_lit("slt_pos",  3'd3, 32'h00000001, 32'hFFFFFFFF, 32'h0, 0, 0, 1);
    op_lit("and",  3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
    op_lit("nand", 3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0, 0);
    op_lit("or",   3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0);
    op_lit("nor",  3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0);
    op_lit("xor",  3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0);

    // Backpressure, then back-to-back accept out of DONE.
    start(3'd0, 32'h7FFFFFFF, 32'h00000001);
    wait_result("bp_latency");
    lit("bp_first", 32'h80000000, 0, 1, 0);
    held_r = result; held_c = carry; held_o = overflow; held_z = zero;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_result", result, held_r);
      check("bp_hold_flags", {carry, overflow, zero}, {held_c, held_o, held_z});
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; sel = 3'd1; a = 32'd3; b = 32'd10;
    q.push_back(model(3'd1, 32'd3, 32'd10));
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_out_valid_drop", out_valid, 0);
    wait_result("b2b_latency");
    lit("b2b_sub", 32'hFFFFFFF9, 0, 0, 0);
    release_out();

    // Model-checked sweep over all operations.
    for (int i = 0; i < 16; i++) begin
      start(3'(i % 8), $urandom, (i % 5 == 0) ? 32'h80000000 : $urandom);
      wait_result("sweep_latency");
      release_out();
    end

    // Asynchronous reset in the middle of RUN.
    start(3'd0, 32'h12345678, 32'h11111111);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    lit("midrun_rst", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    op_lit("add_2_3", 3'd0, 32'd2, 32'd3, 32'h5, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("no_stray_out_valid", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
